// File: rtl/pic_pkg.sv
// Shared types and constants for the picture plot sink: screen limits, palette indices,
// FSM state encoding and the buffered pixel record.
package pic_pkg;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    localparam logic [1:0] IDX_0 = 2'd0;
    localparam logic [1:0] IDX_1 = 2'd1;
    localparam logic [1:0] IDX_2 = 2'd2;
    localparam logic [1:0] IDX_3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } sink_state_t;

    // 23-bit FIFO entry: x, y, palette index, end-of-picture marker
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] colour;
        logic       last;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel records; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module pixel_fifo
    import pic_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   push,
    input  logic   pop,
    input  pixel_t push_data,
    output pixel_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    pixel_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pic_plot_sink.sv
// Consumer of the picture-draw pixel stream: buffers pixels, maps palette, drives the VGA plot port.
// Define PIC_TRANSPARENT_EN to make palette index 0 transparent (popped but never plotted).
module pic_plot_sink
    import pic_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF,
    parameter logic [2:0]  PAL0     = 3'b000,
    parameter logic [2:0]  PAL1     = 3'b111,
    parameter logic [2:0]  PAL2     = 3'b100,
    parameter logic [2:0]  PAL3     = 3'b010
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic [1:0]  in_colour,
    input  logic        in_last,
    input  logic        hold,
    output logic        vga_plot,
    output logic [9:0]  vga_x,
    output logic [9:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        frame_done,
    output logic        busy,
    output logic [14:0] pix_count
);

    sink_state_t state;
    sink_state_t next_state;
    pixel_t      in_pix;
    pixel_t      head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        in_bounds;
    logic        transparent;
    logic        visible;

    function automatic logic [2:0] pal_map(input logic [1:0] idx);
        logic [2:0] rgb;
        rgb = PAL0;
        unique case (idx)
            IDX_0: rgb = PAL0;
            IDX_1: rgb = PAL1;
            IDX_2: rgb = PAL2;
            IDX_3: rgb = PAL3;
            default: rgb = PAL0;
        endcase
        return rgb;
    endfunction

    assign in_ready = !full && (state != FLUSH);
    assign busy     = (state != IDLE);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !hold;
    assign in_pix   = '{x: in_x, y: in_y, colour: in_colour, last: in_last};

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .pop       (pop),
        .push_data (in_pix),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign in_bounds = (32'(head.x) < SCREEN_W) && (32'(head.y) < SCREEN_H);
`ifdef PIC_TRANSPARENT_EN
    assign transparent = (head.colour == IDX_0);
`else
    assign transparent = 1'b0;
`endif
    assign visible = in_bounds && !transparent;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Once the last pixel is accepted, input stays closed until it has been popped
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (push) next_state = in_last ? FLUSH : STREAM;
            STREAM:  if (push && in_last) next_state = FLUSH;
            FLUSH:   if (pop && head.last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            frame_done <= 1'b0;
            pix_count  <= '0;
        end else begin
            vga_plot   <= pop && visible;
            frame_done <= pop && head.last;
            if (pop) begin
                vga_x      <= head.x;
                vga_y      <= head.y;
                vga_colour <= pal_map(head.colour);
            end
            // Count restarts for the next picture on the edge after frame_done
            if (frame_done)
                pix_count <= '0;
            else if (pop && visible && (pix_count != 15'h7FFF))
                pix_count <= pix_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pic_plot_sink.sv
// Directed self-checking bench for pic_plot_sink; inputs driven and outputs sampled on the falling edge.
module tb_pic_plot_sink;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [1:0]  in_colour;
    logic        in_last;
    logic        hold;
    logic        vga_plot;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        frame_done;
    logic        busy;
    logic [14:0] pix_count;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    pic_plot_sink dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_last    (in_last),
        .hold       (hold),
        .vga_plot   (vga_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .frame_done (frame_done),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [9:0] x, input logic [9:0] y,
                                 input logic [1:0] c, input logic l, input logic h);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_colour = c;
        in_last   = l;
        hold      = h;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   sent;
        logic readyNow;

        resetn = 1'b0;
        applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_plot",  32'(vga_plot),   0);
        checkOutput("rst_ready", 32'(in_ready),   1);
        checkOutput("rst_busy",  32'(busy),       0);
        checkOutput("rst_count", 32'(pix_count),  0);
        checkOutput("rst_done",  32'(frame_done), 0);
        checkOutput("rst_x",     32'(vga_x),      0);
        resetn = 1'b1;

        // Test 1: reset with three entries queued
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 10'd33, 10'd44, 2'd1, 1'b0, 1'b0);
        @(negedge clk); applyStimulus(1'b1, 10'd1, 10'd1, 2'd1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_plotA", 32'(vga_plot),  1);
        checkOutput("t1_xA",    32'(vga_x),     33);
        checkOutput("t1_cntA",  32'(pix_count), 1);
        applyStimulus(1'b1, 10'd2, 10'd1, 2'd1, 1'b0, 1'b1);
        @(negedge clk); applyStimulus(1'b1, 10'd3, 10'd1, 2'd1, 1'b0, 1'b1);
        @(negedge clk); applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, 1'b1);
        checkOutput("t1_busy",  32'(busy),      1);
        checkOutput("t1_hold",  32'(vga_plot),  0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("t1_rst_x",     32'(vga_x),      0);
        checkOutput("t1_rst_y",     32'(vga_y),      0);
        checkOutput("t1_rst_col",   32'(vga_colour), 0);
        checkOutput("t1_rst_count", 32'(pix_count),  0);
        checkOutput("t1_rst_busy",  32'(busy),       0);
        checkOutput("t1_rst_ready", 32'(in_ready),   1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t1_noplot", 32'(vga_plot),   0);
            checkOutput("t1_nodone", 32'(frame_done), 0);
        end

        // Test 2: five-pixel picture streamed at full rate
        $display("[TB] five-pixel stream");
        applyStimulus(1'b1, 10'd0, 10'd0, 2'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("t2_plot", 32'(vga_plot),   (k >= 2 && k <= 6) ? 1 : 0);
            checkOutput("t2_done", 32'(frame_done), (k == 6) ? 1 : 0);
            if (k >= 2 && k <= 6) begin
                checkOutput("t2_x",   32'(vga_x),      k - 2);
                checkOutput("t2_y",   32'(vga_y),      0);
                checkOutput("t2_col", 32'(vga_colour), 7);
            end
            if (k == 5) checkOutput("t2_flush_ready", 32'(in_ready), 0);
            if (k == 6) checkOutput("t2_count", 32'(pix_count), 5);
            if (k == 7) begin
                checkOutput("t2_count_clr", 32'(pix_count), 0);
                checkOutput("t2_idle",      32'(busy),      0);
                checkOutput("t2_ready",     32'(in_ready),  1);
            end
            if (k <= 4) applyStimulus(1'b1, 10'(k), 10'd0, 2'd1, (k == 4), 1'b0);
            else        applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, 1'b0);
        end

        // Test 3: hold back-pressure fills the FIFO, then drains in order
        $display("[TB] hold and drain");
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 10'(10 + sent), 10'd20, 2'd2, 1'b0, 1'b1);
            checkOutput("t3_ready",  32'(in_ready), (c < 4) ? 1 : 0);
            checkOutput("t3_noplot", 32'(vga_plot), 0);
            readyNow = in_ready;
            @(negedge clk);
            if (readyNow) sent++;
        end
        checkOutput("t3_sent", 32'(sent), 4);
        applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("t3_plot", 32'(vga_plot), (k <= 4) ? 1 : 0);
            if (k <= 4) begin
                checkOutput("t3_x",   32'(vga_x),      10 + k - 1);
                checkOutput("t3_y",   32'(vga_y),      20);
                checkOutput("t3_col", 32'(vga_colour), 4);
            end
            if (k == 4) checkOutput("t3_count", 32'(pix_count), 4);
        end

        // Test 4: out-of-bounds pixels, then the picture's last pixel
        $display("[TB] out-of-bounds pixels");
        applyStimulus(1'b1, 10'd160, 10'd5, 2'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("t4_plot",  32'(vga_plot),   (k == 4) ? 1 : 0);
            checkOutput("t4_done",  32'(frame_done), (k == 4) ? 1 : 0);
            checkOutput("t4_count", 32'(pix_count),  (k < 4) ? 4 : ((k == 4) ? 5 : 0));
            if (k == 4) begin
                checkOutput("t4_x",   32'(vga_x),      5);
                checkOutput("t4_y",   32'(vga_y),      5);
                checkOutput("t4_col", 32'(vga_colour), 2);
            end
            if      (k == 1) applyStimulus(1'b1, 10'd3, 10'd120, 2'd1, 1'b0, 1'b0);
            else if (k == 2) applyStimulus(1'b1, 10'd5, 10'd5,   2'd3, 1'b1, 1'b0);
            else             applyStimulus(1'b0, 10'd0, 10'd0,   2'd0, 1'b0, 1'b0);
        end

        // Test 5: palette index 0 pixel as a single-pixel picture
        $display("[TB] index-0 pixel");
        applyStimulus(1'b1, 10'd7, 10'd7, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_ready", 32'(in_ready), 0);
        checkOutput("t5_busy",  32'(busy),     1);
        applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_done", 32'(frame_done), 1);
`ifdef PIC_TRANSPARENT_EN
        checkOutput("t5_plot",  32'(vga_plot),  0);
        checkOutput("t5_count", 32'(pix_count), 0);
`else
        checkOutput("t5_plot",  32'(vga_plot),   1);
        checkOutput("t5_count", 32'(pix_count),  1);
        checkOutput("t5_col",   32'(vga_colour), 0);
        checkOutput("t5_x",     32'(vga_x),      7);
`endif
        @(negedge clk);
        checkOutput("t5_idle",  32'(busy),      0);
        checkOutput("t5_clr",   32'(pix_count), 0);

        // Test 6: single pixel held in FLUSH until hold is released
        $display("[TB] single pixel with hold");
        applyStimulus(1'b1, 10'd9, 10'd9, 2'd1, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("t6_ready", 32'(in_ready), 0);
            checkOutput("t6_busy",  32'(busy),     1);
            checkOutput("t6_plot",  32'(vga_plot), 0);
            applyStimulus(1'b0, 10'd0, 10'd0, 2'd0, 1'b0, (k < 3));
        end
        @(negedge clk);
        checkOutput("t6_plot_rel", 32'(vga_plot),   1);
        checkOutput("t6_x",        32'(vga_x),      9);
        checkOutput("t6_col",      32'(vga_colour), 7);
        checkOutput("t6_done",     32'(frame_done), 1);
        checkOutput("t6_count",    32'(pix_count),  1);
        checkOutput("t6_ready_rel",32'(in_ready),   1);
        @(negedge clk);
        checkOutput("t6_done_off", 32'(frame_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
